// File: rtl/ucsbece154b_victim_pkg.sv
// Shared definitions for the L1 victim path (victim writer and victim cache).
// Holds the default address/line widths, helpers that split an address
// into offset and tag, and the packed queue/cache entry layout.
package ucsbece154b_victim_pkg;

   localparam int VC_ADDR_WIDTH = 56;
   localparam int VC_LINE_WIDTH = 128;

   // Number of byte/bit offset bits below the tag for a given line width.
   function automatic int offset_width(input int line_width);
      return $clog2(line_width);
   endfunction

   // Tag bits left above the offset.
   function automatic int tag_width(input int addr_width, input int line_width);
      return addr_width - $clog2(line_width);
   endfunction

   // One victim line: data, full address, and an occupancy flag.
   typedef struct packed {
      logic [VC_LINE_WIDTH-1:0] data;
      logic [VC_ADDR_WIDTH-1:0] addr;
      logic                     valid;
   } victim_entry_t;

endpackage

// File: rtl/ucsbece154b_victim_tag_match.sv
// N-entry tag comparator used for victim lookups and eviction coalescing.
// Ports:
//   valid_i   per-entry valid mask (caller may clear bits to exclude entries)
//   addr_i    per-entry full addresses
//   query_i   address to compare; only the tag field participates
//   hit_vec_o one-hot hit vector (at most one bit set by construction)
//   idx_o     index of the matching entry; 0 when nothing matches
module ucsbece154b_victim_tag_match
   import ucsbece154b_victim_pkg::*;
#(
   parameter int N          = 2,
   parameter int ADDR_WIDTH = VC_ADDR_WIDTH,
   parameter int LINE_WIDTH = VC_LINE_WIDTH,
   parameter int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]                 valid_i,
   input  logic [N-1:0][ADDR_WIDTH-1:0] addr_i,
   input  logic [ADDR_WIDTH-1:0]        query_i,
   output logic [N-1:0]                 hit_vec_o,
   output logic [IDX_W-1:0]             idx_o
);

   localparam int OFF   = offset_width(LINE_WIDTH);
   localparam int TAG_W = tag_width(ADDR_WIDTH, LINE_WIDTH);

   logic [TAG_W-1:0] query_tag;
   logic             unused_offset_bits;

   assign query_tag = query_i[ADDR_WIDTH-1:OFF];

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      hit_vec_o = '0;
      idx_o     = '0;
      for (int i = 0; i < N; i++) begin
         if (valid_i[i] && (addr_i[i][ADDR_WIDTH-1:OFF] == query_tag)) begin
            hit_vec_o[i] = 1'b1;
            idx_o        = IDX_W'(i);
         end
      end
   end

   // Offset bits never take part in the compare.
   always_comb begin
      unused_offset_bits = ^query_i[OFF-1:0];
      for (int i = 0; i < N; i++) begin
         unused_offset_bits = unused_offset_bits ^ (^addr_i[i][OFF-1:0]);
      end
   end

endmodule

// File: rtl/ucsbece154b_victim_writer.sv
// Eviction-side initiator for the L1 victim cache.
// Queues evicted lines in a circular buffer, merges repeat evictions of a
// queued line, drains one line per cycle into the victim cache write port,
// and answers combinational lookups against lines still in the queue.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             discard every queued victim at the next edge
//   hold_i              block draining this cycle
//   evict_*             eviction handshake, address and line data
//   lkp_addr_i/lkp_*    lookup address, hit flag and matching data
//   vc_we_o/waddr/wdata victim cache write port (head entry)
//   count_o             number of queued entries
module ucsbece154b_victim_writer
   import ucsbece154b_victim_pkg::*;
#(
   // Widths must match the package entry layout.
   parameter int ADDR_WIDTH = VC_ADDR_WIDTH,
   parameter int LINE_WIDTH = VC_LINE_WIDTH,
   parameter int DEPTH      = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         hold_i,
   input  logic                         evict_valid_i,
   output logic                         evict_ready_o,
   input  logic [ADDR_WIDTH-1:0]        evict_addr_i,
   input  logic [LINE_WIDTH-1:0]        evict_data_i,
   input  logic [ADDR_WIDTH-1:0]        lkp_addr_i,
   output logic                         lkp_hit_o,
   output logic [LINE_WIDTH-1:0]        lkp_data_o,
   output logic                         vc_we_o,
   output logic [ADDR_WIDTH-1:0]        vc_waddr_o,
   output logic [LINE_WIDTH-1:0]        vc_wdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   victim_entry_t               entries_q [DEPTH];
   victim_entry_t               entries_d [DEPTH];
   logic [IDX_W-1:0]            head_q, head_d;
   logic [IDX_W-1:0]            tail_q, tail_d;
   logic [CNT_W-1:0]            count_q, count_d;

   logic [DEPTH-1:0]                  valid_vec;
   logic [DEPTH-1:0]                  co_valid;
   logic [DEPTH-1:0][ADDR_WIDTH-1:0]  addr_vec;
   logic [DEPTH-1:0]                  lkp_vec, co_vec;
   logic [IDX_W-1:0]                  lkp_idx, co_idx;
   logic                              drain_fire, accept, co_hit, push;

   // Pointers wrap by explicit compare so DEPTH need not be a power of two.
   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign drain_fire    = (count_q != '0) && !hold_i && !flush_i;
   // A full queue still accepts when its head leaves in the same cycle.
   assign evict_ready_o = !flush_i && ((count_q < CNT_W'(DEPTH)) || drain_fire);
   assign accept        = evict_valid_i && evict_ready_o;
   assign co_hit        = |co_vec;
   assign push          = accept && !co_hit;

   // The entry draining this cycle is excluded from coalescing: its data is
   // already on the write port, so a repeat eviction must become a new entry.
   always_comb begin
      valid_vec = '0;
      co_valid  = '0;
      addr_vec  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = entries_q[i].valid;
         addr_vec[i]  = entries_q[i].addr;
         co_valid[i]  = entries_q[i].valid && !(drain_fire && (head_q == IDX_W'(i)));
      end
   end

   ucsbece154b_victim_tag_match #(
      .N(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .LINE_WIDTH(LINE_WIDTH), .IDX_W(IDX_W)
   ) u_lkp_match (
      .valid_i(valid_vec), .addr_i(addr_vec), .query_i(lkp_addr_i),
      .hit_vec_o(lkp_vec), .idx_o(lkp_idx)
   );

   ucsbece154b_victim_tag_match #(
      .N(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .LINE_WIDTH(LINE_WIDTH), .IDX_W(IDX_W)
   ) u_co_match (
      .valid_i(co_valid), .addr_i(addr_vec), .query_i(evict_addr_i),
      .hit_vec_o(co_vec), .idx_o(co_idx)
   );

   assign lkp_hit_o  = |lkp_vec;
   assign lkp_data_o = lkp_hit_o ? entries_q[lkp_idx].data : '0;

   assign vc_we_o    = drain_fire;
   assign vc_waddr_o = entries_q[head_q].addr;
   assign vc_wdata_o = entries_q[head_q].data;
   assign count_o    = count_q;

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_d[i].valid = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (drain_fire) begin
            entries_d[head_q].valid = 1'b0;
            head_d = next_ptr(head_q);
         end
         if (accept && co_hit) begin
            entries_d[co_idx].data = evict_data_i;
         end
         // When full and draining, tail equals head; this write lands after
         // the drain clears the slot, refilling it with the new victim.
         if (push) begin
            entries_d[tail_q].data  = evict_data_i;
            entries_d[tail_q].addr  = evict_addr_i;
            entries_d[tail_q].valid = 1'b1;
            tail_d = next_ptr(tail_q);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(drain_fire);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: the whole entry array is reset, not just the valid bits; the write port is driven from it and must be defined out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: tb/tb_ucsbece154b_victim_writer.sv
module tb_ucsbece154b_victim_writer;

   localparam int AW  = 56;
   localparam int LW  = 128;
   localparam int OFF = 7;

   typedef struct {
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
   } wr_t;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Shared reset; one DEPTH=2 and one DEPTH=3 instance.
   logic          rst_i = 1'b1;
   logic          flush_i = 1'b0, hold_i = 1'b0, ev_valid = 1'b0;
   logic [AW-1:0] ev_addr = '0, lkp_addr = '0;
   logic [LW-1:0] ev_data = '0;
   logic          ev_ready, lkp_hit, vc_we;
   logic [LW-1:0] lkp_data, vc_wdata;
   logic [AW-1:0] vc_waddr;
   logic [1:0]    count;

   logic          d3_flush = 1'b0, d3_hold = 1'b0, d3_valid = 1'b0;
   logic [AW-1:0] d3_addr = '0, d3_lkp_addr = '0;
   logic [LW-1:0] d3_data = '0;
   logic          d3_ready, d3_lkp_hit, d3_we;
   logic [LW-1:0] d3_lkp_data, d3_wdata;
   logic [AW-1:0] d3_waddr;
   logic [1:0]    d3_count;

   wr_t sb2[$];
   wr_t sb3[$];
   int  errors = 0;
   int  checks = 0;

   ucsbece154b_victim_writer #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH(2)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .hold_i(hold_i),
      .evict_valid_i(ev_valid), .evict_ready_o(ev_ready),
      .evict_addr_i(ev_addr), .evict_data_i(ev_data),
      .lkp_addr_i(lkp_addr), .lkp_hit_o(lkp_hit), .lkp_data_o(lkp_data),
      .vc_we_o(vc_we), .vc_waddr_o(vc_waddr), .vc_wdata_o(vc_wdata),
      .count_o(count)
   );

   ucsbece154b_victim_writer #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH(3)) u_dut3 (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(d3_flush), .hold_i(d3_hold),
      .evict_valid_i(d3_valid), .evict_ready_o(d3_ready),
      .evict_addr_i(d3_addr), .evict_data_i(d3_data),
      .lkp_addr_i(d3_lkp_addr), .lkp_hit_o(d3_lkp_hit), .lkp_data_o(d3_lkp_data),
      .vc_we_o(d3_we), .vc_waddr_o(d3_waddr), .vc_wdata_o(d3_wdata),
      .count_o(d3_count)
   );

   task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Scoreboard monitors: each victim cache write must match the oldest
   // expected line of its instance.
   always @(negedge clk_i) begin : mon2
      wr_t e;
      if (!rst_i && vc_we) begin
         if (sb2.size() == 0) begin
            check("d2_unexpected_write", LW'(vc_waddr), LW'(0));
         end else begin
            e = sb2.pop_front();
            check("d2_waddr", LW'(vc_waddr), LW'(e.addr));
            check("d2_wdata", vc_wdata, e.data);
         end
      end
   end

   always @(negedge clk_i) begin : mon3
      wr_t e;
      if (!rst_i && d3_we) begin
         if (sb3.size() == 0) begin
            check("d3_unexpected_write", LW'(d3_waddr), LW'(0));
         end else begin
            e = sb3.pop_front();
            check("d3_waddr", LW'(d3_waddr), LW'(e.addr));
            check("d3_wdata", d3_wdata, e.data);
         end
      end
   end

   // Drives one eviction for one cycle (caller aligned just after a posedge),
   // checks ready before the edge and updates the expected write stream.
   task automatic evict(input bit sel3, input logic [AW-1:0] a, input logic [LW-1:0] d,
                        input bit exp_ready, input bit coalesce);
      wr_t e;
      e.addr = a;
      e.data = d;
      if (sel3) begin
         d3_valid = 1'b1; d3_addr = a; d3_data = d;
      end else begin
         ev_valid = 1'b1; ev_addr = a; ev_data = d;
      end
      @(negedge clk_i);
      if (sel3) check("d3_ready", LW'(d3_ready), LW'(exp_ready));
      else      check("d2_ready", LW'(ev_ready), LW'(exp_ready));
      if (coalesce) begin
         // Merge into the queued line with the same tag.
         if (sel3) begin
            foreach (sb3[i]) if (sb3[i].addr[AW-1:OFF] == a[AW-1:OFF]) sb3[i].data = d;
         end else begin
            foreach (sb2[i]) if (sb2[i].addr[AW-1:OFF] == a[AW-1:OFF]) sb2[i].data = d;
         end
      end else if (sel3) begin
         sb3.push_back(e);
      end else begin
         sb2.push_back(e);
      end
      step();
      if (sel3) d3_valid = 1'b0;
      else      ev_valid = 1'b0;
   endtask

   initial begin
      wr_t e;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Reset state.
      @(negedge clk_i);
      check("rst_count", LW'(count), LW'(0));
      check("rst_we", LW'(vc_we), LW'(0));
      check("rst_hit", LW'(lkp_hit), LW'(0));
      check("rst_ready", LW'(ev_ready), LW'(1));

      // Single eviction, written one cycle after acceptance.
      step();
      evict(0, 56'h80, {16{8'hA5}}, 1, 0);
      @(negedge clk_i);
      check("single_count_1", LW'(count), LW'(1));
      @(negedge clk_i);
      check("single_count_0", LW'(count), LW'(0));

      // Fill under hold, then drain in FIFO order.
      step();
      hold_i = 1'b1;
      evict(0, 56'h100, {4{32'h1111_0100}}, 1, 0);
      evict(0, 56'h180, {4{32'h2222_0180}}, 1, 0);
      @(negedge clk_i);
      check("full_count", LW'(count), LW'(2));
      check("full_ready", LW'(ev_ready), LW'(0));
      check("full_we_held", LW'(vc_we), LW'(0));
      lkp_addr = 56'h180;
      #1;
      check("full_lkp_hit", LW'(lkp_hit), LW'(1));
      check("full_lkp_data", lkp_data, {4{32'h2222_0180}});
      step();
      hold_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("fifo_count_0", LW'(count), LW'(0));

      // Coalescing: same tag, data overwritten in place, single write.
      step();
      hold_i   = 1'b1;
      lkp_addr = 56'h200;
      ev_valid = 1'b1; ev_addr = 56'h200; ev_data = LW'(1);
      e.addr = 56'h200; e.data = LW'(1);
      @(negedge clk_i);
      check("co_ready", LW'(ev_ready), LW'(1));
      check("lkp_same_cycle", LW'(lkp_hit), LW'(0));
      sb2.push_back(e);
      step();
      ev_valid = 1'b0;
      evict(0, 56'h27F, LW'(2), 1, 1);
      @(negedge clk_i);
      check("co_count", LW'(count), LW'(1));
      check("co_lkp_hit", LW'(lkp_hit), LW'(1));
      check("co_lkp_data", lkp_data, LW'(2));
      lkp_addr = 56'h27F;
      #1;
      check("co_lkp_hit_alias", LW'(lkp_hit), LW'(1));
      step();
      hold_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("co_count_0", LW'(count), LW'(0));

      // Full queue with simultaneous drain and enqueue (tail wraps).
      step();
      hold_i = 1'b1;
      evict(0, 56'h400, {2{64'h4444_4444_0000_0400}}, 1, 0);
      evict(0, 56'h480, {2{64'h5555_5555_0000_0480}}, 1, 0);
      @(negedge clk_i);
      check("wrap_full_count", LW'(count), LW'(2));
      check("wrap_full_ready", LW'(ev_ready), LW'(0));
      step();
      hold_i = 1'b0;
      evict(0, 56'h300, {2{64'h6666_6666_0000_0300}}, 1, 0);
      @(negedge clk_i);
      check("wrap_count_kept", LW'(count), LW'(2));
      repeat (3) @(negedge clk_i);
      check("wrap_count_0", LW'(count), LW'(0));

      // Flush discards queued victims with no write that cycle.
      step();
      hold_i = 1'b1;
      evict(0, 56'h500, LW'(5), 1, 0);
      evict(0, 56'h580, LW'(6), 1, 0);
      lkp_addr = 56'h500;
      #1;
      check("pre_flush_hit", LW'(lkp_hit), LW'(1));
      hold_i  = 1'b0;
      flush_i = 1'b1;
      sb2.delete();
      @(negedge clk_i);
      check("flush_we", LW'(vc_we), LW'(0));
      check("flush_ready", LW'(ev_ready), LW'(0));
      step();
      flush_i = 1'b0;
      @(negedge clk_i);
      check("flush_count", LW'(count), LW'(0));
      check("flush_lkp_a", LW'(lkp_hit), LW'(0));
      check("flush_lkp_data", lkp_data, LW'(0));
      lkp_addr = 56'h580;
      #1;
      check("flush_lkp_b", LW'(lkp_hit), LW'(0));

      // Asynchronous reset while a write is on the port.
      step();
      hold_i = 1'b1;
      evict(0, 56'h600, LW'(7), 1, 0);
      evict(0, 56'h680, LW'(8), 1, 0);
      lkp_addr = 56'h680;
      hold_i   = 1'b0;
      @(negedge clk_i);
      check("pre_rst_we", LW'(vc_we), LW'(1));
      #2 rst_i = 1'b1;
      #1;
      check("async_rst_we", LW'(vc_we), LW'(0));
      check("async_rst_count", LW'(count), LW'(0));
      check("async_rst_hit", LW'(lkp_hit), LW'(0));
      sb2.delete();
      step();
      rst_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_ready", LW'(ev_ready), LW'(1));

      // DEPTH=3 instance: fill, push-and-pop when full, then keep streaming
      // so both pointers wrap past index 2.
      step();
      d3_hold = 1'b1;
      evict(1, 56'h700, LW'(32'h700), 1, 0);
      evict(1, 56'h780, LW'(32'h780), 1, 0);
      evict(1, 56'h800, LW'(32'h800), 1, 0);
      @(negedge clk_i);
      check("d3_full_count", LW'(d3_count), LW'(3));
      check("d3_full_ready", LW'(d3_ready), LW'(0));
      step();
      d3_hold = 1'b0;
      evict(1, 56'h880, LW'(32'h880), 1, 0);
      evict(1, 56'h900, LW'(32'h900), 1, 0);
      evict(1, 56'h980, LW'(32'h980), 1, 0);
      @(negedge clk_i);
      check("d3_stream_count", LW'(d3_count), LW'(3));
      repeat (4) @(negedge clk_i);
      check("d3_count_0", LW'(d3_count), LW'(0));

      // Every expected write must have been seen.
      repeat (2) @(negedge clk_i);
      check("d2_sb_empty", LW'(sb2.size()), LW'(0));
      check("d3_sb_empty", LW'(sb3.size()), LW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
